// File: rtl/midi_pkg.sv
// Shared MIDI definitions for the voice front-end:
// status codes, parser states and data width.
package midi_pkg;

    localparam logic [7:0] ST_NOTE_OFF = 8'h80;
    localparam logic [7:0] ST_NOTE_ON  = 8'h90;
    localparam logic [7:0] ST_SYSTEM   = 8'hF0;
    localparam logic [7:0] ST_REALTIME = 8'hF8;

    localparam int DATA_W = 7;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_D1,
        WAIT_D2,
        SKIP
    } parse_state_t;

endpackage

// File: rtl/midi_voice_frontend_if.sv
// Received-byte bus between the SPI byte assembler
// and the MIDI parser.
interface midi_voice_frontend_if;

    logic [7:0] data;
    logic       valid;

    modport master (
        output data,
        output valid
    );

    modport slave (
        input data,
        input valid
    );

endinterface

// File: rtl/spi_byte_rx.sv
// Synchronises the asynchronous SPI lines and assembles
// MSB-first bytes, one bit per synchronised sclk rise.
module spi_byte_rx (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  mosi,
    midi_voice_frontend_if.master rx
);

    logic [2:0] sclk_sync;
    logic [1:0] mosi_sync;
    logic [2:0] bit_cnt;
    logic [6:0] shift;
    logic       rise;

    // third sclk stage only serves edge detection
    assign rise = sclk_sync[1] & ~sclk_sync[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            rx.data   <= '0;
            rx.valid  <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[1:0], sclk};
            mosi_sync <= {mosi_sync[0], mosi};
            rx.valid  <= 1'b0;
            if (rise) begin
                shift   <= {shift[5:0], mosi_sync[1]};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    rx.data  <= {shift, mosi_sync[1]};
                    rx.valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/midi_voice_frontend.sv
// MIDI-over-SPI front-end: parses note-on/off messages
// with running status and allocates them to voice slots.
module midi_voice_frontend
    import midi_pkg::*;
#(
    parameter int NUM_VOICES   = 4,
    parameter int MIDI_CHANNEL = 0,
    parameter int OMNI         = 0
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_SPI_sclk,
    input  logic                         i_SPI_mosi,
    output logic [NUM_VOICES-1:0]        o_voice_gate,
    output logic [DATA_W*NUM_VOICES-1:0] o_voice_note,
    output logic [DATA_W*NUM_VOICES-1:0] o_voice_vel,
    output logic                         o_byte_valid,
    output logic [7:0]                   o_byte,
    output logic [1:0]                   o_byte_counter,
    output logic                         o_drop
);

    midi_voice_frontend_if rx_bus ();

    spi_byte_rx u_rx (
        .clk  (i_clk),
        .rst  (i_reset),
        .sclk (i_SPI_sclk),
        .mosi (i_SPI_mosi),
        .rx   (rx_bus.master)
    );

    assign o_byte_valid = rx_bus.valid;
    assign o_byte       = rx_bus.data;

    logic [7:0] b;
    logic       is_rt;
    logic       is_sys;
    logic       is_status;
    logic       is_note_msg;
    logic       chan_ok;

    assign b           = rx_bus.data;
    assign is_rt       = b >= ST_REALTIME;
    assign is_sys      = (b >= ST_SYSTEM) && !is_rt;
    assign is_status   = b[7] && !is_sys && !is_rt;
    assign is_note_msg = (b[7:4] == ST_NOTE_OFF[7:4]) ||
                         (b[7:4] == ST_NOTE_ON[7:4]);
    assign chan_ok     = (OMNI != 0) ||
                         (b[3:0] == 4'(MIDI_CHANNEL));

    parse_state_t state;
    parse_state_t state_d;
    logic         set_rs;
    logic         clr_rs;
    logic         store_note;
    logic         emit;

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= IDLE;
        else         state <= state_d;
    end

    always_comb begin
        state_d = state;
        if (rx_bus.valid && !is_rt) begin
            if (is_sys) begin
                state_d = IDLE;
            end else if (is_status) begin
                state_d = (is_note_msg && chan_ok) ? WAIT_D1 : SKIP;
            end else begin
                unique case (state)
                    WAIT_D1: state_d = WAIT_D2;
                    WAIT_D2: state_d = WAIT_D1;
                    default: state_d = state;
                endcase
            end
        end
    end

    always_comb begin
        set_rs     = 1'b0;
        clr_rs     = 1'b0;
        store_note = 1'b0;
        emit       = 1'b0;
        if (rx_bus.valid && !is_rt) begin
            if (is_sys) begin
                clr_rs = 1'b1;
            end else if (is_status) begin
                set_rs = is_note_msg && chan_ok;
                clr_rs = !(is_note_msg && chan_ok);
            end else begin
                store_note = state == WAIT_D1;
                emit       = state == WAIT_D2;
            end
        end
    end

    logic              rs_on;
    logic [DATA_W-1:0] note_d1;
    logic              evt;
    logic              evt_on;
    logic [DATA_W-1:0] evt_note;
    logic [DATA_W-1:0] evt_vel;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rs_on          <= 1'b0;
            note_d1        <= '0;
            evt            <= 1'b0;
            evt_on         <= 1'b0;
            evt_note       <= '0;
            evt_vel        <= '0;
            o_byte_counter <= '0;
        end else begin
            evt <= emit;
            if (rx_bus.valid) o_byte_counter <= o_byte_counter + 2'd1;
            // bit 4 separates 0x9n (on) from 0x8n (off)
            if (set_rs)      rs_on <= b[4];
            else if (clr_rs) rs_on <= 1'b0;
            if (store_note) note_d1 <= b[DATA_W-1:0];
            if (emit) begin
                evt_on   <= rs_on && (b[DATA_W-1:0] != '0);
                evt_note <= note_d1;
                evt_vel  <= b[DATA_W-1:0];
            end
        end
    end

    logic [NUM_VOICES-1:0] gate;
    logic [DATA_W-1:0]     note [NUM_VOICES];
    logic [DATA_W-1:0]     vel  [NUM_VOICES];
    logic [NUM_VOICES-1:0] hit;
    logic [NUM_VOICES-1:0] free;
    logic [NUM_VOICES-1:0] hit_first;
    logic [NUM_VOICES-1:0] free_first;

    always_comb begin
        hit  = '0;
        free = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            hit[v]  = gate[v] && (note[v] == evt_note);
            free[v] = !gate[v];
        end
        hit_first  = hit & (-hit);
        free_first = free & (-free);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            gate   <= '0;
            o_drop <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                note[v] <= '0;
                vel[v]  <= '0;
            end
        end else begin
            o_drop <= 1'b0;
            if (evt) begin
                if (!evt_on) begin
                    gate <= gate & ~hit;
                end else if (|hit) begin
                    for (int v = 0; v < NUM_VOICES; v++) begin
                        if (hit_first[v]) vel[v] <= evt_vel;
                    end
                end else if (|free) begin
                    for (int v = 0; v < NUM_VOICES; v++) begin
                        if (free_first[v]) begin
                            gate[v] <= 1'b1;
                            note[v] <= evt_note;
                            vel[v]  <= evt_vel;
                        end
                    end
                end else begin
                    o_drop <= 1'b1;
                end
            end
        end
    end

    assign o_voice_gate = gate;

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_pack
        assign o_voice_note[DATA_W*v +: DATA_W] = note[v];
        assign o_voice_vel[DATA_W*v +: DATA_W]  = vel[v];
    end

endmodule
